// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio types for the I2S receive path
package audio_pkg;

  localparam int AUDIO_DATA_W = 16;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_t;

  typedef struct packed {
    logic [AUDIO_DATA_W-1:0] left;
    logic [AUDIO_DATA_W-1:0] right;
  } sample_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// rtl/i2s_sync_edge.sv - multi-flop synchronizer with rising-edge detect on one lane
module i2s_sync_edge #(
  parameter int STAGES = 2,
  parameter int W      = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         edge_in,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic         rise
);

  // Lane 0 carries edge_in so its edge stays cycle-aligned with the data lanes.
  logic [W:0] chain [STAGES];
  logic [W:0] dly;
  logic       prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      dly  <= '0;
      prev <= 1'b0;
    end else begin
      chain[0] <= {din, edge_in};
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      dly  <= chain[STAGES-1];
      prev <= dly[0];
    end
  end

  assign sync = dly[W:1];
  assign rise = dly[0] & ~prev;

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - Philips I2S slave receiver, oversampled in the system clock domain
module i2s_rx
  import audio_pkg::*;
#(
  parameter int DATA_W      = AUDIO_DATA_W,
  parameter int MAX_SLOT    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  input  logic              i2s_bck,
  input  logic              i2s_lrck,
  input  logic              i2s_data,
  output logic [DATA_W-1:0] L_data,
  output logic [DATA_W-1:0] R_data,
  output logic              sample_valid,
  output logic              locked,
  output logic              slot_err
);

  localparam int CNT_W = $clog2(MAX_SLOT + 2);

  logic [1:0] sync_sig;
  logic       rise;
  logic       lrck_s;
  logic       data_s;

  i2s_sync_edge #(.STAGES(SYNC_STAGES), .W(2)) u_sync (
    .clk     (clk_50MHz),
    .rst     (reset),
    .edge_in (i2s_bck),
    .din     ({i2s_lrck, i2s_data}),
    .sync    (sync_sig),
    .rise    (rise)
  );

  assign {lrck_s, data_s} = sync_sig;

  logic [DATA_W-1:0] shreg, shreg_n, l_hold, l_hold_n, l_data_n, r_data_n;
  logic [DATA_W-1:0] shifted, word;
  logic [CNT_W-1:0]  cnt, cnt_n;
  channel_t          ch, ch_n;
  logic              seen_fall, seen_fall_n, locked_n, valid_n, err_n, bad;
  int                n;

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      shreg        <= '0;
      cnt          <= '0;
      ch           <= CH_LEFT;
      l_hold       <= '0;
      seen_fall    <= 1'b0;
      L_data       <= '0;
      R_data       <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      slot_err     <= 1'b0;
    end else begin
      shreg        <= shreg_n;
      cnt          <= cnt_n;
      ch           <= ch_n;
      l_hold       <= l_hold_n;
      seen_fall    <= seen_fall_n;
      L_data       <= l_data_n;
      R_data       <= r_data_n;
      sample_valid <= valid_n;
      locked       <= locked_n;
      slot_err     <= err_n;
    end
  end

  always_comb begin
    shreg_n     = shreg;
    cnt_n       = cnt;
    ch_n        = ch;
    l_hold_n    = l_hold;
    l_data_n    = L_data;
    r_data_n    = R_data;
    seen_fall_n = seen_fall;
    locked_n    = locked;
    valid_n     = 1'b0;
    err_n       = 1'b0;

    // The boundary bit still belongs to the slot being closed, hence n = cnt + 1.
    n       = int'(cnt) + 1;
    bad     = (n < DATA_W) || (n > MAX_SLOT);
    shifted = (int'(cnt) < DATA_W) ? {shreg[DATA_W-2:0], data_s} : shreg;
    word    = (n < DATA_W) ? (shifted << (DATA_W - n)) : shifted;

    if (rise) begin
      if (channel_t'(lrck_s) == ch) begin
        shreg_n = shifted;
        cnt_n   = (int'(cnt) == MAX_SLOT + 1) ? cnt : cnt + 1'b1;
      end else begin
        shreg_n = '0;
        cnt_n   = '0;
        ch_n    = channel_t'(lrck_s);
        if (ch == CH_LEFT) begin
          l_hold_n = word;
          if (!bad && seen_fall) locked_n = 1'b1;
        end else begin
          seen_fall_n = 1'b1;
          if (!bad && locked) begin
            l_data_n = l_hold;
            r_data_n = word;
            valid_n  = 1'b1;
          end
        end
        // A malformed slot forces a full relock starting from the next left slot.
        if (bad) begin
          err_n       = 1'b1;
          locked_n    = 1'b0;
          seen_fall_n = 1'b0;
        end
      end
    end
  end

endmodule
